// File: rtl/exbus_pkg.sv
// Shared state encoding and burst-length limit for the external-bus requester.
package exbus_pkg;
  typedef enum logic [2:0] {IDLE, REQ, ADDR, STRB, END, REL} state_t;
  localparam int LEN_MAX = 16;
endpackage

// File: rtl/exbus_master.sv
// External-bus requester: arbitrates with EXBREQ_N/EXBACK_N, then runs a
// 1-16 word burst on CS0 with BS_N/RD_N/WE_N strobes honouring WAIT_N.
module exbus_master
  import exbus_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        START,
  input  logic        START_WR,
  input  logic [23:0] START_ADDR,
  input  logic [3:0]  START_LEN,
  input  logic [15:0] WDATA,
  output logic        WDATA_ACK,
  output logic [15:0] RDATA,
  output logic        RDATA_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        EXBREQ_N,
  input  logic        EXBACK_N,
  output logic [23:0] A,
  output logic [15:0] DO,
  output logic        DO_EN,
  input  logic [15:0] DI,
  output logic        BS_N,
  output logic        CS0_N,
  output logic        RD_WR_N,
  output logic        RD_N,
  output logic [1:0]  WE_N,
  input  logic        WAIT_N
);
  state_t      state_q;
  logic [23:0] addr_q, a_q;
  logic [4:0]  cnt_q;
  logic        wr_q, lost_q;
  logic        exbreq_n_q, bs_n_q, cs0_n_q, rd_wr_n_q, rd_n_q, do_en_q;
  logic [1:0]  we_n_q;
  logic [15:0] do_q, rdata_q;
  logic        wdata_ack_q, rdata_valid_q, done_q, err_q;
  logic [23:0] addr_d;
  logic [4:0]  cnt_d, len_d;
  logic        go_addr;
  logic        ce_f_unused;

  assign ce_f_unused = CE_F;
  assign addr_d = addr_q + 24'd1;
  assign cnt_d  = cnt_q - 5'd1;
  assign len_d  = (START_LEN == 4'd0) ? 5'(LEN_MAX) : {1'b0, START_LEN};

  // A new word starts either on first grant or when a burst continues with the grant intact.
  assign go_addr = CE_R && ((state_q == REQ && !EXBACK_N) ||
                            (state_q == END && cnt_q != 5'd0 && !EXBACK_N && !lost_q));

  always_ff @(posedge CLK) begin
    wdata_ack_q   <= 1'b0;
    rdata_valid_q <= 1'b0;
    done_q        <= 1'b0;
    err_q         <= 1'b0;
    if (RST) begin
      state_q    <= IDLE;
      exbreq_n_q <= 1'b1;
      bs_n_q     <= 1'b1;
      cs0_n_q    <= 1'b1;
      rd_wr_n_q  <= 1'b1;
      rd_n_q     <= 1'b1;
      we_n_q     <= 2'b11;
      a_q        <= 24'd0;
      do_q       <= 16'd0;
      do_en_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else if (CE_R) begin
      unique case (state_q)
        IDLE: if (START) begin
          addr_q     <= START_ADDR;
          wr_q       <= START_WR;
          cnt_q      <= len_d;
          lost_q     <= 1'b0;
          exbreq_n_q <= 1'b0;
          state_q    <= REQ;
        end
        REQ: ;
        ADDR: begin
          bs_n_q <= 1'b1;
          if (wr_q) we_n_q <= 2'b00;
          else      rd_n_q <= 1'b0;
          if (EXBACK_N) lost_q <= 1'b1;
          state_q <= STRB;
        end
        STRB: begin
          if (EXBACK_N) lost_q <= 1'b1;
          if (WAIT_N) begin
            rd_n_q        <= 1'b1;
            we_n_q        <= 2'b11;
            cs0_n_q       <= 1'b1;
            do_en_q       <= 1'b0;
            rdata_valid_q <= !wr_q;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            state_q       <= END;
          end
        end
        END: if (!go_addr) begin
          if (EXBACK_N && cnt_q != 5'd0) lost_q <= 1'b1;
          exbreq_n_q <= 1'b1;
          state_q    <= REL;
        end
        REL: if (EXBACK_N) begin
          done_q  <= 1'b1;
          err_q   <= lost_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (go_addr) begin
        state_q   <= ADDR;
        a_q       <= addr_q;
        bs_n_q    <= 1'b0;
        cs0_n_q   <= 1'b0;
        rd_wr_n_q <= !wr_q;
        if (wr_q) begin
          do_q        <= WDATA;
          do_en_q     <= 1'b1;
          wdata_ack_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CE_R && state_q == STRB && WAIT_N && !wr_q) rdata_q <= DI;
  end

  assign BUSY        = (state_q != IDLE);
  assign EXBREQ_N    = exbreq_n_q;
  assign A           = a_q;
  assign DO          = do_q;
  assign DO_EN       = do_en_q;
  assign BS_N        = bs_n_q;
  assign CS0_N       = cs0_n_q;
  assign RD_WR_N     = rd_wr_n_q;
  assign RD_N        = rd_n_q;
  assign WE_N        = we_n_q;
  assign WDATA_ACK   = wdata_ack_q;
  assign RDATA       = rdata_q;
  assign RDATA_VALID = rdata_valid_q;
  assign DONE        = done_q;
  assign ERR         = err_q;
endmodule

// File: tb/tb_exbus_master.sv
// Bench for exbus_master: acts as bus controller and checks each burst
// against addresses, data and edge counts derived from the burst parameters.
module tb_exbus_master;
  logic        CLK = 1'b0;
  logic        RST, CE_R, CE_F, START, START_WR;
  logic [23:0] START_ADDR;
  logic [3:0]  START_LEN;
  logic [15:0] WDATA, RDATA, DO, DI;
  logic        WDATA_ACK, RDATA_VALID, BUSY, DONE, ERR, EXBREQ_N, EXBACK_N;
  logic [23:0] A;
  logic        DO_EN, BS_N, CS0_N, RD_WR_N, RD_N, WAIT_N;
  logic [1:0]  WE_N;

  always #5 CLK = ~CLK;

  exbus_master dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .START(START), .START_WR(START_WR),
    .START_ADDR(START_ADDR), .START_LEN(START_LEN), .WDATA(WDATA), .WDATA_ACK(WDATA_ACK),
    .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .EXBREQ_N(EXBREQ_N), .EXBACK_N(EXBACK_N), .A(A), .DO(DO), .DO_EN(DO_EN), .DI(DI),
    .BS_N(BS_N), .CS0_N(CS0_N), .RD_WR_N(RD_WR_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(WAIT_N)
  );

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [3:0]  len;
    int          gdelay;
    int          waits;
    int          drop;
    bit          xstart;
    int          exp_words;
    bit          exp_err;
    logic [23:0] exp_last;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int          w  [16];
  logic [15:0] wd [16];
  logic [15:0] rd [16];
  bit          rand_ce;
  logic [23:0] obs_a [$];
  logic [15:0] obs_d [$];
  int n_ack, n_done, n_rv, overlap, phase_bad, strb_cyc, err_seen;
  int bs_edge, g_edge, rel_edge, ackhi_edge, done_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plays the bus controller for one burst and records what the master did.
  task automatic run_burst(input bit wr, input logic [23:0] addr, input logic [3:0] len,
                           input int gdelay, input int drop, input bit xstart);
    int word, waits_left, gcnt, cyc, ce_cnt;
    bit bs_prev, strb_prev, req_prev, dropped, xs_done, strobe;
    bit ce_in, ack_in, req_in, wait_in, strb_in;
    obs_a.delete(); obs_d.delete();
    n_ack = 0; n_done = 0; n_rv = 0; overlap = 0; phase_bad = 0; strb_cyc = 0; err_seen = 0;
    bs_edge = -1; g_edge = -1; rel_edge = -1; ackhi_edge = -1; done_edge = -1;
    word = -1; waits_left = 0; gcnt = 0; cyc = 0;
    bs_prev = 1; strb_prev = 0; req_prev = 0; dropped = 0; xs_done = 0;
    START_WR = wr; START_ADDR = addr; START_LEN = len; WDATA = wd[0]; DI = rd[0];
    EXBACK_N = 1; WAIT_N = 1; CE_R = 1; START = 1;
    @(posedge CLK); #1;
    START = 0; ce_cnt = 1;
    check("req_latency", EXBREQ_N, 1'b0);
    check("busy_on_req", BUSY, 1'b1);
    while (n_done == 0 && cyc < 3000) begin
      strobe = !RD_N || (WE_N == 2'b00);
      if (!RD_N && WE_N != 2'b11) overlap++;
      if (!BS_N && bs_prev) begin
        word++;
        obs_a.push_back(A);
        waits_left = w[word & 15];
        DI = rd[word & 15];
        if (bs_edge < 0) bs_edge = ce_cnt;
        if (RD_WR_N !== !wr || CS0_N !== 1'b0) phase_bad++;
      end
      if (strobe && !strb_prev) begin
        if (word < 0 || A !== obs_a[$] || CS0_N !== 1'b0 || RD_WR_N !== !wr) phase_bad++;
        if (wr) obs_d.push_back(DO);
        if (drop == word + 1) dropped = 1;
      end
      if (strobe) strb_cyc++;
      if (WDATA_ACK) begin n_ack++; WDATA = wd[n_ack & 15]; end
      if (RDATA_VALID) begin n_rv++; obs_d.push_back(RDATA); end
      if (EXBREQ_N && !req_prev) rel_edge = ce_cnt;
      if (DONE) begin n_done++; err_seen = ERR; done_edge = ce_cnt; end
      bs_prev = BS_N; strb_prev = strobe; req_prev = EXBREQ_N;
      CE_R = rand_ce ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (EXBREQ_N || dropped) EXBACK_N = 1;
      else if (EXBACK_N) begin
        if (gcnt >= gdelay) EXBACK_N = 0;
        else gcnt++;
      end
      WAIT_N = !(strobe && waits_left > 0);
      START = xstart && !xs_done && !EXBREQ_N && word < 0;
      if (START) xs_done = 1;
      ce_in = CE_R; ack_in = EXBACK_N; req_in = EXBREQ_N; wait_in = WAIT_N; strb_in = strobe;
      @(posedge CLK); #1;
      cyc++;
      if (ce_in) begin
        ce_cnt++;
        if (strb_in && !wait_in) waits_left--;
        if (!ack_in && !req_in && g_edge < 0) g_edge = ce_cnt;
        if (ack_in && req_in && rel_edge >= 0 && ackhi_edge < 0) ackhi_edge = ce_cnt;
      end
    end
    START = 0; EXBACK_N = 1; WAIT_N = 1; CE_R = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (DONE) n_done++;
      if (!EXBREQ_N || BUSY) phase_bad++;
    end
  endtask

  task automatic check_burst(input string tag, input bit wr, input logic [23:0] addr,
                             input int exp_words, input bit exp_err);
    int wsum;
    logic [23:0] ea;
    wsum = 0;
    for (int i = 0; i < exp_words; i++) wsum += w[i];
    check({tag, "_words"}, obs_a.size(), exp_words);
    check({tag, "_ndata"}, obs_d.size(), exp_words);
    for (int i = 0; i < exp_words && i < obs_a.size(); i++) begin
      ea = addr + 24'(i);
      check({tag, "_addr"}, obs_a[i], ea);
    end
    for (int i = 0; i < exp_words && i < obs_d.size(); i++)
      check({tag, "_data"}, obs_d[i], wr ? wd[i] : rd[i]);
    check({tag, "_wdata_ack"}, n_ack, wr ? exp_words : 0);
    check({tag, "_rdata_valid"}, n_rv, wr ? 0 : exp_words);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_grant_to_bs"}, bs_edge, g_edge);
    check({tag, "_burst_edges"}, rel_edge - bs_edge, 3 * exp_words + wsum);
    check({tag, "_done_timing"}, done_edge, ackhi_edge);
    check({tag, "_strobe_overlap"}, overlap, 0);
    check({tag, "_phase"}, phase_bad, 0);
    if (!rand_ce) check({tag, "_strobe_cycles"}, strb_cyc, exp_words + wsum);
  endtask

  initial begin
    vec_t tv [6];
    bit          r_wr;
    logic [23:0] r_addr;
    logic [3:0]  r_len;
    int          r_n, r_drop, dones, guard;

    tv[0] = '{1'b1, 24'h100000, 4'd2, 2, 0, 0, 1'b0, 2,  1'b0, 24'h100001};
    tv[1] = '{1'b0, 24'h000040, 4'd1, 0, 3, 0, 1'b0, 1,  1'b0, 24'h000040};
    tv[2] = '{1'b0, 24'hFFFFFE, 4'd0, 1, 0, 0, 1'b0, 16, 1'b0, 24'h00000D};
    tv[3] = '{1'b1, 24'h000200, 4'd4, 1, 1, 2, 1'b0, 2,  1'b1, 24'h000201};
    tv[4] = '{1'b0, 24'h123456, 4'd3, 3, 0, 0, 1'b1, 3,  1'b0, 24'h123458};
    tv[5] = '{1'b1, 24'hFFFFFF, 4'd1, 0, 2, 0, 1'b0, 1,  1'b0, 24'hFFFFFF};

    RST = 1; CE_R = 1; CE_F = 0; START = 0; START_WR = 0; START_ADDR = 0; START_LEN = 0;
    WDATA = 0; EXBACK_N = 1; DI = 0; WAIT_N = 1; rand_ce = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_exbreq_n", EXBREQ_N, 1'b1);
    check("rst_bs_n", BS_N, 1'b1);
    check("rst_cs0_n", CS0_N, 1'b1);
    check("rst_rd_n", RD_N, 1'b1);
    check("rst_rd_wr_n", RD_WR_N, 1'b1);
    check("rst_we_n", WE_N, 2'b11);
    check("rst_a", A, 24'd0);
    check("rst_do", DO, 16'd0);
    check("rst_do_en", DO_EN, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_pulses", {DONE, ERR, WDATA_ACK, RDATA_VALID}, 4'b0000);
    RST = 0;
    @(posedge CLK); #1;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) begin
        w[i]  = tv[k].waits;
        wd[i] = 16'h5000 + 16'(i * 16'h0111);
        rd[i] = 16'hA55A ^ 16'(i * 16'h1111);
      end
      run_burst(tv[k].wr, tv[k].addr, tv[k].len, tv[k].gdelay, tv[k].drop, tv[k].xstart);
      check_burst($sformatf("vec%0d", k), tv[k].wr, tv[k].addr, tv[k].exp_words, tv[k].exp_err);
      check($sformatf("vec%0d_last_addr", k), (obs_a.size() > 0) ? obs_a[$] : 24'hDEAD00, tv[k].exp_last);
    end

    // Reset while the read strobe is active: bus must drop at once with no DONE.
    START_WR = 0; START_ADDR = 24'h000777; START_LEN = 4'd4; START = 1; EXBACK_N = 0; WAIT_N = 0;
    @(posedge CLK); #1;
    START = 0;
    guard = 0;
    while (RD_N && guard < 10) begin @(posedge CLK); #1; guard++; end
    check("rstmid_in_strobe", RD_N, 1'b0);
    RST = 1;
    @(posedge CLK); #1;
    check("rstmid_exbreq_n", EXBREQ_N, 1'b1);
    check("rstmid_rd_n", RD_N, 1'b1);
    check("rstmid_cs0_n", CS0_N, 1'b1);
    check("rstmid_busy", BUSY, 1'b0);
    RST = 0; EXBACK_N = 1; WAIT_N = 1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) dones++;
    end
    check("rstmid_no_done", dones, 0);

    rand_ce = 1;
    for (int t = 0; t < 20; t++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 24'($urandom());
      r_len  = 4'($urandom_range(0, 15));
      r_n    = (r_len == 4'd0) ? 16 : int'(r_len);
      r_drop = 0;
      if (r_n > 1 && $urandom_range(0, 3) == 0) r_drop = $urandom_range(1, r_n - 1);
      for (int i = 0; i < 16; i++) begin
        w[i]  = $urandom_range(0, 2);
        wd[i] = 16'($urandom());
        rd[i] = 16'($urandom());
      end
      run_burst(r_wr, r_addr, r_len, $urandom_range(0, 3), r_drop, 1'($urandom_range(0, 1)));
      check_burst($sformatf("rnd%0d", t), r_wr, r_addr, (r_drop != 0) ? r_drop : r_n, r_drop != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
